// File: rtl/quad_accel_gen.sv
// Held up/down requests -> accelerating two-phase quadrature stream for the paddle encoder.
// Optional input debounce filter enabled by defining QUAD_DEBOUNCE_EN.
module quad_accel_gen #(
  parameter int unsigned DIV_START  = 2000,
  parameter int unsigned DIV_MIN    = 500,
  parameter int unsigned ACCEL_STEP = 100,
  parameter int unsigned DEB_CYCLES = 1024
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       i_up,
  input  logic       i_down,
  output logic [1:0] o_steer,
  output logic       o_dir,
  output logic       o_moving
);

  localparam int unsigned CNT_W  = 16;
  localparam int unsigned CNT_W1 = CNT_W + 1;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] RUN_UP = 2'd1;
  localparam logic [1:0] RUN_DN = 2'd2;

  localparam logic [CNT_W-1:0]  PERIOD_START = CNT_W'(DIV_START);
  localparam logic [CNT_W-1:0]  PERIOD_MIN   = CNT_W'(DIV_MIN);
  localparam logic [CNT_W-1:0]  PERIOD_ACCEL = CNT_W'(ACCEL_STEP);
  // Periods at or above this value can shrink by a full step without passing DIV_MIN.
  localparam logic [CNT_W1-1:0] SAT_LIMIT    = CNT_W1'(DIV_MIN + ACCEL_STEP);

  if (DIV_MIN < 2 || DIV_MIN > DIV_START || DIV_START > 65535 || DEB_CYCLES < 1) begin : gBadParams
    $error("quad_accel_gen: illegal divider/debounce parameters");
  end

  logic [1:0]       upSync, dnSync;
  logic             upReq, dnReq;
  logic [1:0]       state, stateNext;
  logic [1:0]       phase, phaseNext;
  logic [CNT_W-1:0] cnt, cntNext;
  logic [CNT_W-1:0] period, periodNext;
  logic             dirNext;
  logic             step;

  // Two-flop synchronizers on the asynchronous requests.
  always_ff @(posedge clock) begin
    if (reset) begin
      upSync <= '0;
      dnSync <= '0;
    end else begin
      upSync <= {upSync[0], i_up};
      dnSync <= {dnSync[0], i_down};
    end
  end

`ifdef QUAD_DEBOUNCE_EN
  localparam int unsigned DEB_W = $clog2(DEB_CYCLES + 1);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

  logic [DEB_W-1:0] upCnt, dnCnt;

  // A filtered request flips only after the synchronized input disagreed for DEB_CYCLES cycles.
  always_ff @(posedge clock) begin
    if (reset) begin
      upCnt <= '0;
      dnCnt <= '0;
      upReq <= 1'b0;
      dnReq <= 1'b0;
    end else begin
      if (upSync[1] == upReq) begin
        upCnt <= '0;
      end else if (upCnt == DEB_LAST) begin
        upCnt <= '0;
        upReq <= upSync[1];
      end else begin
        upCnt <= upCnt + DEB_W'(1);
      end
      if (dnSync[1] == dnReq) begin
        dnCnt <= '0;
      end else if (dnCnt == DEB_LAST) begin
        dnCnt <= '0;
        dnReq <= dnSync[1];
      end else begin
        dnCnt <= dnCnt + DEB_W'(1);
      end
    end
  end
`else
  assign upReq = upSync[1];
  assign dnReq = dnSync[1];
`endif

  // Next state, step timing and acceleration.
  always_comb begin
    stateNext  = IDLE;
    phaseNext  = phase;
    cntNext    = '0;
    periodNext = PERIOD_START;
    dirNext    = o_dir;
    step       = 1'b0;
    if (upReq && !dnReq) begin
      stateNext = RUN_UP;
    end else if (dnReq && !upReq) begin
      stateNext = RUN_DN;
    end
    if (stateNext != IDLE) begin
      if (stateNext != state) begin
        step    = 1'b1;
        dirNext = (stateNext == RUN_DN);
      end else if (cnt == period - CNT_W'(1)) begin
        step       = 1'b1;
        periodNext = ({1'b0, period} >= SAT_LIMIT) ? period - PERIOD_ACCEL : PERIOD_MIN;
      end else begin
        cntNext    = cnt + CNT_W'(1);
        periodNext = period;
      end
    end
    if (step) begin
      phaseNext = (stateNext == RUN_DN) ? phase + 2'd1 : phase - 2'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      phase    <= '0;
      cnt      <= '0;
      period   <= PERIOD_START;
      o_steer  <= 2'b00;
      o_dir    <= 1'b0;
      o_moving <= 1'b0;
    end else begin
      state    <= stateNext;
      phase    <= phaseNext;
      cnt      <= cntNext;
      period   <= periodNext;
      o_steer  <= {phaseNext[1], phaseNext[1] ^ phaseNext[0]};
      o_dir    <= dirNext;
      o_moving <= (stateNext != IDLE);
    end
  end

endmodule

// File: tb/tb_quad_accel_gen.sv
// Scoreboard bench for quad_accel_gen; expectations adapt when QUAD_DEBOUNCE_EN is defined.
module tb_quad_accel_gen;

`ifdef QUAD_DEBOUNCE_EN
  localparam int LAT = 3 + 4;
  localparam bit DEB = 1'b1;
`else
  localparam int LAT = 3;
  localparam bit DEB = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       i_up = 1'b0;
  logic       i_down = 1'b0;
  logic [1:0] o_steer;
  logic       o_dir;
  logic       o_moving;

  quad_accel_gen #(
    .DIV_START(8), .DIV_MIN(4), .ACCEL_STEP(2), .DEB_CYCLES(4)
  ) dut (
    .clock(clock), .reset(reset), .i_up(i_up), .i_down(i_down),
    .o_steer(o_steer), .o_dir(o_dir), .o_moving(o_moving)
  );

  always #5 clock = ~clock;

  int         vectors = 0;
  int         miscompares = 0;
  int         gap = 0;
  bit         changed = 1'b0;
  logic [1:0] prevSteer = 2'b00;

  logic [1:0] expSteerQ[$];
  int         expGapQ[$];
  logic       expDirQ[$];

  // Advance one edge and sample 1 time unit later; tracks o_steer changes and edge count.
  task automatic tick();
    @(posedge clock);
    #1;
    changed   = (o_steer !== prevSteer);
    prevSteer = o_steer;
    gap++;
  endtask

  task automatic push(input logic [1:0] s, input int g, input logic d);
    expSteerQ.push_back(s);
    expGapQ.push_back(g);
    expDirQ.push_back(d);
  endtask

  task automatic clear_sb();
    expSteerQ.delete();
    expGapQ.delete();
    expDirQ.delete();
  endtask

  task automatic do_reset();
    reset = 1'b1; i_up = 1'b0; i_down = 1'b0;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      i_up = 1'($urandom_range(0, 1));
      i_down = 1'($urandom_range(0, 1));
      tick();
      vectors++;
      if (o_steer !== 2'b00 || o_dir !== 1'b0 || o_moving !== 1'b0) begin
        miscompares++;
        $display("FAIL reset: steer=%b dir=%b moving=%b, want 00/0/0", o_steer, o_dir, o_moving);
      end
    end
    i_up = 1'b0; i_down = 1'b0;
    reset = 1'b0;
    tick(); tick();
  endtask

  task automatic test_down_accel();
    logic [1:0] es, held; int eg; logic ed;
    clear_sb();
    push(2'b01, LAT, 1); push(2'b11, 8, 1); push(2'b10, 6, 1); push(2'b00, 4, 1);
    push(2'b01, 4, 1); push(2'b11, 4, 1); push(2'b10, 4, 1);
    i_down = 1'b1; gap = 0;
    for (int c = 0; c < 120 && expSteerQ.size() > 0; c++) begin
      tick();
      if (changed) begin
        es = expSteerQ.pop_front(); eg = expGapQ.pop_front(); ed = expDirQ.pop_front();
        vectors += 2;
        if (o_steer !== es || o_dir !== ed || o_moving !== 1'b1) begin
          miscompares++;
          $display("FAIL down_step: steer=%b dir=%b moving=%b, want steer=%b dir=%b moving=1", o_steer, o_dir, o_moving, es, ed);
        end
        if (gap !== eg) begin
          miscompares++;
          $display("FAIL down_interval: got %0d cycles, want %0d", gap, eg);
        end
        gap = 0;
      end
    end
    if (expSteerQ.size() != 0) begin
      vectors++; miscompares++;
      $display("FAIL down_timeout: %0d steps never seen", expSteerQ.size());
    end
    i_down = 1'b0;
    for (int c = 0; c <= LAT; c++) tick();
    held = o_steer;
    for (int c = 0; c < 6; c++) tick();
    vectors++;
    if (o_steer !== held || o_moving !== 1'b0 || o_dir !== 1'b1) begin
      miscompares++;
      $display("FAIL down_release: steer=%b dir=%b moving=%b, want steer=%b dir=1 moving=0", o_steer, o_dir, o_moving, held);
    end
  endtask

  task automatic test_up_from_reset();
    logic [1:0] es; int eg; logic ed;
    do_reset();
    clear_sb();
    push(2'b10, LAT, 0); push(2'b11, 8, 0); push(2'b01, 6, 0); push(2'b00, 4, 0);
    i_up = 1'b1; gap = 0;
    for (int c = 0; c < 80 && expSteerQ.size() > 0; c++) begin
      tick();
      if (changed) begin
        es = expSteerQ.pop_front(); eg = expGapQ.pop_front(); ed = expDirQ.pop_front();
        vectors += 2;
        if (o_steer !== es || o_dir !== ed || o_moving !== 1'b1) begin
          miscompares++;
          $display("FAIL up_step: steer=%b dir=%b moving=%b, want steer=%b dir=%b moving=1", o_steer, o_dir, o_moving, es, ed);
        end
        if (gap !== eg) begin
          miscompares++;
          $display("FAIL up_interval: got %0d cycles, want %0d", gap, eg);
        end
        gap = 0;
      end
    end
    if (expSteerQ.size() != 0) begin
      vectors++; miscompares++;
      $display("FAIL up_timeout: %0d steps never seen", expSteerQ.size());
    end
    i_up = 1'b0;
    for (int c = 0; c <= LAT; c++) tick();
  endtask

  task automatic test_simultaneous();
    logic [1:0] held;
    held = o_steer;
    i_up = 1'b1; i_down = 1'b1;
    for (int c = 0; c < 50; c++) begin
      tick();
      vectors++;
      if (o_steer !== held || o_moving !== 1'b0) begin
        miscompares++;
        $display("FAIL both_held: cycle %0d steer=%b moving=%b, want steer=%b moving=0", c, o_steer, o_moving, held);
      end
    end
    i_up = 1'b0; i_down = 1'b0;
    for (int c = 0; c <= LAT; c++) tick();
  endtask

  task automatic test_reversal();
    logic [1:0] es; int eg; logic ed;
    do_reset();
    i_down = 1'b1;
    for (int c = 0; c < 40 && o_steer !== 2'b11; c++) tick();
    vectors++;
    if (o_steer !== 2'b11) begin
      miscompares++;
      $display("FAIL rev_reach11: steer=%b, want 11", o_steer);
    end
    i_down = 1'b0; i_up = 1'b1; gap = 0;
    clear_sb();
    if (DEB) begin
      push(2'b10, 6, 1); push(2'b11, 1, 0); push(2'b01, 8, 0);
    end else begin
      push(2'b01, 3, 0); push(2'b00, 8, 0);
    end
    for (int c = 0; c < 60 && expSteerQ.size() > 0; c++) begin
      tick();
      if (changed) begin
        es = expSteerQ.pop_front(); eg = expGapQ.pop_front(); ed = expDirQ.pop_front();
        vectors += 2;
        if (o_steer !== es || o_dir !== ed || o_moving !== 1'b1) begin
          miscompares++;
          $display("FAIL rev_step: steer=%b dir=%b moving=%b, want steer=%b dir=%b moving=1", o_steer, o_dir, o_moving, es, ed);
        end
        if (gap !== eg) begin
          miscompares++;
          $display("FAIL rev_interval: got %0d cycles, want %0d", gap, eg);
        end
        gap = 0;
      end
    end
    if (expSteerQ.size() != 0) begin
      vectors++; miscompares++;
      $display("FAIL rev_timeout: %0d steps never seen", expSteerQ.size());
    end
    i_up = 1'b0;
    for (int c = 0; c <= LAT; c++) tick();
  endtask

  task automatic test_reset_midrun();
    logic [1:0] es; int eg; logic ed;
    do_reset();
    i_down = 1'b1;
    for (int c = 0; c < 20 && o_steer !== 2'b01; c++) tick();
    tick(); tick();
    reset = 1'b1;
    tick();
    vectors++;
    if (o_steer !== 2'b00 || o_dir !== 1'b0 || o_moving !== 1'b0) begin
      miscompares++;
      $display("FAIL midrun_reset: steer=%b dir=%b moving=%b, want 00/0/0", o_steer, o_dir, o_moving);
    end
    reset = 1'b0; gap = 0;
    clear_sb();
    push(2'b01, LAT, 1); push(2'b11, 8, 1);
    for (int c = 0; c < 40 && expSteerQ.size() > 0; c++) begin
      tick();
      if (changed) begin
        es = expSteerQ.pop_front(); eg = expGapQ.pop_front(); ed = expDirQ.pop_front();
        vectors += 2;
        if (o_steer !== es || o_dir !== ed || o_moving !== 1'b1) begin
          miscompares++;
          $display("FAIL midrun_step: steer=%b dir=%b moving=%b, want steer=%b dir=%b moving=1", o_steer, o_dir, o_moving, es, ed);
        end
        if (gap !== eg) begin
          miscompares++;
          $display("FAIL midrun_interval: got %0d cycles, want %0d", gap, eg);
        end
        gap = 0;
      end
    end
    if (expSteerQ.size() != 0) begin
      vectors++; miscompares++;
      $display("FAIL midrun_timeout: %0d steps never seen", expSteerQ.size());
    end
    i_down = 1'b0;
    for (int c = 0; c <= LAT; c++) tick();
  endtask

  task automatic test_debounce();
    int         changes;
    logic [1:0] wantSteer;
    int         wantChanges;
    do_reset();
    tick();
    changes = 0;
    i_down = 1'b1;
    tick(); if (changed) changes++;
    tick(); if (changed) changes++;
    i_down = 1'b0;
    for (int c = 0; c < 30; c++) begin
      tick();
      if (changed) changes++;
    end
    wantSteer   = DEB ? 2'b00 : 2'b01;
    wantChanges = DEB ? 0 : 1;
    vectors += 2;
    if (changes !== wantChanges || o_steer !== wantSteer) begin
      miscompares++;
      $display("FAIL pulse_steps: %0d changes ending at %b, want %0d ending at %b", changes, o_steer, wantChanges, wantSteer);
    end
    if (o_moving !== 1'b0) begin
      miscompares++;
      $display("FAIL pulse_idle: moving=%b, want 0", o_moving);
    end
  endtask

  initial begin
    test_reset();
    test_down_accel();
    test_up_from_reset();
    test_simultaneous();
    test_reversal();
    test_reset_midrun();
    test_debounce();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
